// File: rtl/serial_multiplier.sv
// ============================================================================
// serial_multiplier : 32x32 radix-2 shift-add multiplier with optional 64-bit
// accumulate. Option macro: EARLY_TERM_EN (early MULT exit). Rev 1.0
// ============================================================================
`default_nettype none

`ifndef WordWidth
`define WordWidth 32
`endif

module serial_multiplier (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_Start,
  input  logic                  in_Signed,
  input  logic                  in_Accumulate,
  input  logic [`WordWidth-1:0] in_OperandA,
  input  logic [`WordWidth-1:0] in_OperandB,
  input  logic [`WordWidth-1:0] in_AccHi,
  input  logic [`WordWidth-1:0] in_AccLo,
  output logic                  out_Busy,
  output logic                  out_Valid,
  output logic [`WordWidth-1:0] out_ResultHi,
  output logic [`WordWidth-1:0] out_ResultLo
);

  localparam int W  = `WordWidth;
  localparam int CW = $clog2(W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_MULT  = 3'd2,
    S_FIXUP = 3'd3,
    S_ACC   = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_mplier;
  logic [2*W-1:0]   r_mcand;
  logic [2*W-1:0]   r_prod;
  logic [2*W-1:0]   r_acc;
  logic [CW-1:0]    r_count;
  logic             r_signed;
  logic             r_accen;
  logic             r_neg;
  logic [W-1:0]     w_mag_a;
  logic [W-1:0]     w_mag_b;
  logic [2*W-1:0]   w_sum;
  logic             w_mult_done;

  assign w_mag_a = (r_signed && r_a[W-1])      ? (~r_a + 1'b1)      : r_a;
  assign w_mag_b = (r_signed && r_mplier[W-1]) ? (~r_mplier + 1'b1) : r_mplier;
  assign w_sum   = r_prod + (r_accen ? r_acc : '0);

`ifdef EARLY_TERM_EN
  // Stop once no set multiplier bits remain beyond the one consumed this cycle.
  assign w_mult_done = (r_count == CW'(W-1)) || (r_mplier[W-1:1] == '0);
`else
  assign w_mult_done = (r_count == CW'(W-1));
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    out_Busy = (r_state != S_IDLE);
    case (r_state)
      S_IDLE:  if (in_Start) w_next = S_PREP;
      S_PREP:  w_next = S_MULT;
      S_MULT:  if (w_mult_done) w_next = S_FIXUP;
      S_FIXUP: w_next = S_ACC;
      S_ACC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_a          <= '0;
      r_mplier     <= '0;
      r_mcand      <= '0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_count      <= '0;
      r_signed     <= 1'b0;
      r_accen      <= 1'b0;
      r_neg        <= 1'b0;
      out_Valid    <= 1'b0;
      out_ResultHi <= '0;
      out_ResultLo <= '0;
    end else begin
      out_Valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_Start) begin
            r_a      <= in_OperandA;
            r_mplier <= in_OperandB;
            r_acc    <= {in_AccHi, in_AccLo};
            r_signed <= in_Signed;
            r_accen  <= in_Accumulate;
          end
        end
        S_PREP: begin
          // Magnitudes only; the most negative value maps to itself as unsigned.
          r_mcand  <= {{W{1'b0}}, w_mag_a};
          r_mplier <= w_mag_b;
          r_neg    <= r_signed & (r_a[W-1] ^ r_mplier[W-1]);
          r_prod   <= '0;
          r_count  <= '0;
        end
        S_MULT: begin
          if (r_mplier[0]) r_prod <= r_prod + r_mcand;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
        end
        S_FIXUP: begin
          if (r_neg) r_prod <= ~r_prod + 1'b1;
        end
        S_ACC: begin
          out_ResultHi <= w_sum[2*W-1:W];
          out_ResultLo <= w_sum[W-1:0];
          out_Valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_multiplier.md
SERIAL_MULTIPLIER -- requirements
Module: serial_multiplier

Interface
REQ-001 SHALL provide the following ports:
- clock  input  1  Rising-edge clock; one clock for the whole block.
- reset  input  1  Asynchronous, active-high reset.
- in_Start  input  1  Request strobe; sampled only while out_Busy=0.
- in_Signed  input  1  1: operands are two's complement; 0: operands are unsigned.
- in_Accumulate  input  1  1: add the 64-bit accumulator to the product.
- in_OperandA  input  `WordWidth  Multiplicand.
- in_OperandB  input  `WordWidth  Multiplier.
- in_AccHi  input  `WordWidth  Accumulator, upper word.
- in_AccLo  input  `WordWidth  Accumulator, lower word.
- out_Busy  output  1  Operation in progress.
- out_Valid  output  1  One-cycle pulse; result registers updated.
- out_ResultHi  output  `WordWidth  Product bits 63:32.
- out_ResultLo  output  `WordWidth  Product bits 31:0.

REQ-002 `WordWidth SHALL be 32; every internal width SHALL derive from it.

Function
REQ-003 The FSM SHALL have states IDLE, PREP, MULT, FIXUP and ACC.
REQ-004 In IDLE, in_Start=1 at an edge E0 SHALL latch all operand, accumulator, in_Signed and in_Accumulate inputs, set out_Busy=1 and enter PREP.
REQ-005 In PREP, when in_Signed=1, each negative operand SHALL be replaced by its two's-complement magnitude, and the result sign SHALL be stored as signA XOR signB.
REQ-006 In PREP with in_Signed=0, operands SHALL pass unchanged and the stored result sign SHALL be 0.
REQ-007 0x80000000 in signed mode SHALL yield magnitude 0x80000000, treated as unsigned.
REQ-008 MULT SHALL perform radix-2 shift-add, one multiplier bit per cycle, into a 64-bit partial product, with k iterations (k=32 by default; see REQ-020).
REQ-009 FIXUP SHALL two's-complement the 64-bit product when the stored sign is 1, and SHALL otherwise leave it unchanged.
REQ-010 In ACC, when in_Accumulate=1, the latched accumulator SHALL be added modulo 2^64 with no carry-out or overflow flag.
REQ-011 At the edge leaving ACC, the block SHALL:
- load out_ResultHi and out_ResultLo;
- assert out_Valid for exactly one cycle;
- deassert out_Busy;
- return to IDLE.
REQ-012 Latency from E0 to the edge asserting out_Valid SHALL be 3+k clocks, which is 35 by default.
REQ-013 in_Start while out_Busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-014 in_Start on the same cycle out_Valid is high SHALL be accepted, since the FSM is in IDLE.
REQ-015 Input changes after E0 SHALL NOT affect the operation in progress.
REQ-016 The result registers SHALL hold their value until the next out_Valid.
REQ-017 The lower word of the result SHALL be identical for signed and unsigned modes given the same operand bits.

Reset
REQ-018 reset=1 SHALL immediately, without waiting for clock, force:
- state = IDLE;
- out_Busy = 0;
- out_Valid = 0;
- out_ResultHi = 0 and out_ResultLo = 0;
- iteration counter and partial product = 0.
REQ-019 Reset asserted during an operation SHALL abort it with no out_Valid pulse; the first accepted in_Start is the first edge with reset=0.

Configuration
REQ-020 Macro EARLY_TERM_EN SHALL control early termination of MULT:
- Defined: MULT exits once the remaining unshifted multiplier magnitude is zero after an iteration, so k = max(1, bit-length of |B|) and latency = 3+k, from 4 to 35 clocks.
- Undefined: k = 32 always, fixed latency 35, and the termination-detect logic is absent.
- Results SHALL be identical in both builds.

Verification
REQ-021 The bench SHALL cover:
- Unsigned 3 x 5, acc off -> Hi=0x00000000, Lo=0x0000000F; out_Valid 35 clocks after E0 (macro off).
- Signed 0xFFFFFFFD (-3) x 7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- Signed 0x80000000 x 0x80000000 -> Hi=0x40000000, Lo=0x00000000; unsigned 0xFFFFFFFF x 0xFFFFFFFF with acc 0x00000000_00000001 -> Hi=0xFFFFFFFE, Lo=0x00000002.
- Signed 2 x 3, acc 0xFFFFFFFF_FFFFFFFF -> Hi=0, Lo=5; second in_Start 5 cycles after E0 -> ignored, exactly one out_Valid.
- reset asserted 10 clocks after E0 -> out_Busy=0, results 0, no out_Valid; new in_Start 2 x 2 -> Lo=4.
- EARLY_TERM_EN defined, B=1 or B=0 -> out_Valid 4 clocks after E0; B=0x80000000 -> 35 clocks, with results matching the macro-off build.
